sdram_ctrl_init: RTL and testbench

Power-up initialisation sequencer for the SDRAM controller.
- Issues the JEDEC start-up command sequence on the SDRAM command/address pins: stable-clock wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE REGISTER.
- Hands the pins over to the command engine (sdram_ctrl_ramif) by asserting init_done.
- Sits directly upstream of sdram_ctrl_ramif on the pin path. The top level muxes the init outputs onto the pins while init_done=0.
- Takes its timing (cl, t_rp, t_ref) and ctrl_en from sdram_ctrl_regs.

---
 rtl/sdram_ctrl_init_pkg.sv | 28 ++
 rtl/sdram_ctrl_init_if.sv | 30 +++
 rtl/sdram_ctrl_init.sv | 145 ++++++++++++++
 tb/tb_sdram_ctrl_init.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_ctrl_init_pkg.sv
// Shared SDRAM command encodings and mode-register layout for the init sequencer.
// The command engine (ramif) uses the same encodings.
package sdram_ctrl_init_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [3:0] {
        CMD_LMR   = 4'b0000,
        CMD_REF   = 4'b0001,
        CMD_PRE   = 4'b0010,
        CMD_NOP   = 4'b0111,
        CMD_DESEL = 4'b1111
    } sdram_cmd_e;

    localparam int         A_AP_BIT   = 10;
    localparam logic [2:0] MR_BL2     = 3'b001;
    localparam logic       MR_BT_SEQ  = 1'b0;
    localparam logic [1:0] MR_OP_STD  = 2'b00;
    localparam logic       MR_WB_BURST = 1'b0;
    localparam logic [2:0] MR_CL_DEF  = 3'd3;

    // Unsupported CAS latencies fall back to 3, which is always safe at speed.
    function automatic logic [12:0] mode_word(input logic [2:0] cl);
        logic [2:0] cl_eff;
        cl_eff = (cl == 3'd2 || cl == 3'd3) ? cl : MR_CL_DEF;
        return {3'b000, MR_WB_BURST, MR_OP_STD, cl_eff, MR_BT_SEQ, MR_BL2};
    endfunction

endpackage

// File: rtl/sdram_ctrl_init_if.sv
// Configuration inputs and SDRAM pin outputs of the init sequencer.
// master = sequencer side, slave = pin mux / register side.
interface sdram_ctrl_init_if;
    import sdram_ctrl_init_pkg::*;

    logic        ctrl_en;
    logic [2:0]  cl;
    logic [2:0]  t_rp;
    logic [2:0]  t_ref;
    logic        cke_o;
    logic        cs_n_o;
    logic        ras_n_o;
    logic        cas_n_o;
    logic        we_n_o;
    logic [12:0] a_o;
    logic [1:0]  ba_o;
    logic        busy_o;
    logic        init_done_o;

    modport master (
        input  ctrl_en, cl, t_rp, t_ref,
        output cke_o, cs_n_o, ras_n_o, cas_n_o, we_n_o, a_o, ba_o, busy_o, init_done_o
    );

    modport slave (
        output ctrl_en, cl, t_rp, t_ref,
        input  cke_o, cs_n_o, ras_n_o, cas_n_o, we_n_o, a_o, ba_o, busy_o, init_done_o
    );

endinterface

// File: rtl/sdram_ctrl_init.sv
// SDRAM power-up sequencer: clock-stable wait, PRECHARGE ALL, REF_CNT x AUTO REFRESH,
// LOAD MODE, then hands the pins to the command engine via init_done_o.
//
// state      | meaning
// S_IDLE     | deselected, CKE low, waiting for ctrl_en
// S_WAIT     | CKE high, NOP for WAIT_CYCLES
// S_PRE      | PRECHARGE ALL issued
// S_WAIT_RP  | tRP NOPs
// S_REF      | AUTO REFRESH issued
// S_WAIT_RFC | tRFC NOPs
// S_LMR      | LOAD MODE issued
// S_WAIT_MRD | tMRD NOPs
// S_DONE     | init complete, terminal until rst
module sdram_ctrl_init
    import sdram_ctrl_init_pkg::*;
#(
    parameter int WAIT_CYCLES = 20000,
    parameter int REF_CNT     = 8,
    parameter int T_MRD       = 2,
    parameter int CNT_WIDTH   = 15
) (
    input logic clk,
    input logic rst,
    sdram_ctrl_init_if.master bus
);

    localparam int REF_W = $clog2(REF_CNT + 1);
    localparam logic [REF_W-1:0]     REF_LAST  = REF_W'(REF_CNT - 1);
    localparam logic [REF_W-1:0]     REF_TOTAL = REF_W'(REF_CNT);
    localparam logic [CNT_WIDTH-1:0] CNT_WAIT  = CNT_WIDTH'(WAIT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MRD   = CNT_WIDTH'(T_MRD - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT, S_PRE, S_WAIT_RP, S_REF, S_WAIT_RFC, S_LMR, S_WAIT_MRD, S_DONE
    } state_e;

    state_e             state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [REF_W-1:0]   ref_num;
    sdram_cmd_e         cmd_q;
    logic               cke_q;
    logic [12:0]        a_q;
    logic [1:0]         ba_q;
    logic               busy_q;
    logic               done_q;
    logic [2:0]         rp_m1;
    logic [2:0]         rfc_m1;

    // Zero periods are treated as one cycle, i.e. no extra NOPs.
    assign rp_m1  = (bus.t_rp  == 3'd0) ? 3'd0 : bus.t_rp  - 3'd1;
    assign rfc_m1 = (bus.t_ref == 3'd0) ? 3'd0 : bus.t_ref - 3'd1;

    // Pin outputs follow the state one cycle later, always from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ref_num <= '0;
            cmd_q   <= CMD_DESEL;
            cke_q   <= 1'b0;
            a_q     <= '0;
            ba_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cmd_q  <= CMD_NOP;
            cke_q  <= 1'b1;
            a_q    <= '0;
            ba_q   <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    cmd_q  <= CMD_DESEL;
                    cke_q  <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.ctrl_en) begin
                        state <= S_WAIT;
                        cnt   <= CNT_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt <= CNT_ONE) state <= S_PRE;
                    else                cnt   <= cnt - CNT_ONE;
                end
                S_PRE: begin
                    cmd_q         <= CMD_PRE;
                    a_q[A_AP_BIT] <= 1'b1;
                    if (rp_m1 == 3'd0) begin
                        state <= S_REF;
                    end else begin
                        cnt   <= CNT_WIDTH'(rp_m1);
                        state <= S_WAIT_RP;
                    end
                end
                S_WAIT_RP: begin
                    if (cnt <= CNT_ONE) state <= S_REF;
                    else                cnt   <= cnt - CNT_ONE;
                end
                S_REF: begin
                    cmd_q   <= CMD_REF;
                    ref_num <= ref_num + REF_W'(1);
                    if (rfc_m1 == 3'd0) begin
                        state <= (ref_num == REF_LAST) ? S_LMR : S_REF;
                    end else begin
                        cnt   <= CNT_WIDTH'(rfc_m1);
                        state <= S_WAIT_RFC;
                    end
                end
                S_WAIT_RFC: begin
                    if (cnt <= CNT_ONE) state <= (ref_num == REF_TOTAL) ? S_LMR : S_REF;
                    else                cnt   <= cnt - CNT_ONE;
                end
                S_LMR: begin
                    cmd_q <= CMD_LMR;
                    a_q   <= mode_word(bus.cl);
                    if (T_MRD <= 1) begin
                        state <= S_DONE;
                    end else begin
                        cnt   <= CNT_MRD;
                        state <= S_WAIT_MRD;
                    end
                end
                S_WAIT_MRD: begin
                    if (cnt <= CNT_ONE) state <= S_DONE;
                    else                cnt   <= cnt - CNT_ONE;
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign {bus.cs_n_o, bus.ras_n_o, bus.cas_n_o, bus.we_n_o} = cmd_q;
    assign bus.cke_o       = cke_q;
    assign bus.a_o         = a_q;
    assign bus.ba_o        = ba_q;
    assign bus.busy_o      = busy_q;
    assign bus.init_done_o = done_q;

endmodule

// File: tb/tb_sdram_ctrl_init.sv
// Bench for sdram_ctrl_init: per-cycle pin trace compared against a timeline model
// built from the command-spacing rules; a second instance checks REF_CNT=8.
module tb_sdram_ctrl_init;

    localparam int W     = 10;
    localparam int T_MRD = 2;
    localparam int NREF  = 2;
    localparam int NREF8 = 8;

    logic clk = 1'b0;
    logic rst;
    logic rst8;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sdram_ctrl_init_if bus();
    sdram_ctrl_init_if bus8();

    sdram_ctrl_init #(.WAIT_CYCLES(W), .REF_CNT(NREF), .T_MRD(T_MRD), .CNT_WIDTH(15)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    sdram_ctrl_init #(.WAIT_CYCLES(W), .REF_CNT(NREF8), .T_MRD(T_MRD), .CNT_WIDTH(15)) u_dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (bus8.master)
    );

    localparam logic [21:0] IDLE_V = {1'b0, 4'b1111, 13'd0, 2'd0, 1'b0, 1'b0};
    localparam logic [21:0] DONE_V = {1'b1, 4'b0111, 13'd0, 2'd0, 1'b0, 1'b1};

    function automatic logic [21:0] observe();
        return {bus.cke_o, bus.cs_n_o, bus.ras_n_o, bus.cas_n_o, bus.we_n_o,
                bus.a_o, bus.ba_o, bus.busy_o, bus.init_done_o};
    endfunction

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int done_cycle(input int rp, input int rf, input int nref);
        return W + 1 + eff(rp) + nref * eff(rf) + T_MRD;
    endfunction

    // Expected pins at cycle c, counting c=0 as the edge that samples ctrl_en.
    function automatic logic [21:0] model(input int c, input int rp, input int rf,
                                          input int clv, input int nref);
        int pre, ref0, lmr, cle;
        logic [12:0] mode;
        pre  = W + 1;
        ref0 = pre + eff(rp);
        lmr  = ref0 + nref * eff(rf);
        cle  = (clv == 2 || clv == 3) ? clv : 3;
        mode = 13'(cle * 16 + 1);
        if (c == 0)                return IDLE_V;
        if (c >= lmr + T_MRD)      return DONE_V;
        if (c == pre)              return {1'b1, 4'b0010, 13'h400, 2'd0, 1'b1, 1'b0};
        if (c == lmr)              return {1'b1, 4'b0000, mode, 2'd0, 1'b1, 1'b0};
        for (int k = 0; k < nref; k++)
            if (c == ref0 + k * eff(rf)) return {1'b1, 4'b0001, 13'd0, 2'd0, 1'b1, 1'b0};
        return {1'b1, 4'b0111, 13'd0, 2'd0, 1'b1, 1'b0};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.ctrl_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Caller must be at a negedge with rst low; the next posedge is cycle 0.
    task automatic run_seq(input int rp, input int rf, input int clv,
                           input int drop_at, input string tag);
        int last;
        logic [21:0] exp_v, got;
        bus.t_rp    = 3'(rp);
        bus.t_ref   = 3'(rf);
        bus.cl      = 3'(clv);
        bus.ctrl_en = 1'b1;
        last = done_cycle(rp, rf, NREF) + 6;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            got   = observe();
            exp_v = model(c, rp, rf, clv, NREF);
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL %s cycle=%0d got=%h exp=%h (rp=%0d rf=%0d cl=%0d)",
                         tag, c, got, exp_v, rp, rf, clv);
            end
            if (c == drop_at) bus.ctrl_en = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rst8 = 1'b1;
        bus.ctrl_en = 1'b1;
        bus.cl = 3'd3; bus.t_rp = 3'd2; bus.t_ref = 3'd3;
        bus8.ctrl_en = 1'b0;
        bus8.cl = 3'd3; bus8.t_rp = 3'd2; bus8.t_ref = 3'd3;
        repeat (3) @(negedge clk);
        checks++;
        if (observe() !== IDLE_V) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", observe(), IDLE_V);
        end
        rst = 1'b0;
        bus.ctrl_en = 1'b0;
    endtask

    task automatic test_basic();
        apply_reset();
        run_seq(2, 3, 3, -1, "basic");
    endtask

    task automatic test_zero_timing();
        apply_reset();
        run_seq(0, 0, 5, -1, "zero_timing");
    endtask

    task automatic test_cl2();
        apply_reset();
        run_seq(2, 3, 2, -1, "cl2");
    endtask

    task automatic test_random();
        int rp, rf, clv;
        for (int i = 0; i < 6; i++) begin
            rp  = int'($urandom_range(0, 7));
            rf  = int'($urandom_range(0, 7));
            clv = int'($urandom_range(0, 7));
            apply_reset();
            run_seq(rp, rf, clv, -1, "random");
        end
    endtask

    task automatic test_en_toggle();
        apply_reset();
        run_seq(2, 3, 3, 3, "en_drop_wait");
        apply_reset();
        run_seq(1, 2, 2, done_cycle(1, 2, NREF) + 1, "en_drop_done");
    endtask

    task automatic test_idle_hold();
        apply_reset();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            checks++;
            if (observe() !== IDLE_V) begin
                failures++;
                $display("FAIL idle_hold cycle=%0d got=%h exp=%h", c, observe(), IDLE_V);
            end
        end
    endtask

    task automatic test_reset_mid();
        int ref1;
        logic [21:0] exp_v;
        apply_reset();
        bus.t_rp = 3'd2; bus.t_ref = 3'd3; bus.cl = 3'd3;
        bus.ctrl_en = 1'b1;
        ref1 = W + 1 + 2 + 3;
        for (int c = 0; c <= ref1; c++) @(negedge clk);
        exp_v = model(ref1, 2, 3, 3, NREF);
        checks++;
        if (observe() !== exp_v) begin
            failures++;
            $display("FAIL reset_mid_second_ref got=%h exp=%h", observe(), exp_v);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (observe() !== IDLE_V) begin
            failures++;
            $display("FAIL reset_mid_async got=%h exp=%h", observe(), IDLE_V);
        end
        @(negedge clk);
        rst = 1'b0;
        run_seq(2, 3, 3, -1, "reset_mid_restart");
    endtask

    task automatic test_count8();
        int rp, rf, refs, exp_done, seen_done;
        logic exp_busy;
        rp = int'($urandom_range(0, 4));
        rf = int'($urandom_range(0, 4));
        exp_done  = done_cycle(rp, rf, NREF8);
        refs      = 0;
        seen_done = -1;
        @(negedge clk);
        rst8 = 1'b1;
        repeat (2) @(negedge clk);
        rst8 = 1'b0;
        bus8.t_rp = 3'(rp); bus8.t_ref = 3'(rf); bus8.cl = 3'd3;
        bus8.ctrl_en = 1'b1;
        for (int c = 0; c < 200 && seen_done < 0; c++) begin
            @(negedge clk);
            if ({bus8.cs_n_o, bus8.ras_n_o, bus8.cas_n_o, bus8.we_n_o} == 4'b0001) refs++;
            if (bus8.init_done_o === 1'b1) seen_done = c;
            exp_busy = (c >= 1) && (bus8.init_done_o !== 1'b1);
            checks++;
            if (bus8.busy_o !== exp_busy) begin
                failures++;
                $display("FAIL count8_busy cycle=%0d got=%b exp=%b", c, bus8.busy_o, exp_busy);
            end
        end
        checks++;
        if (seen_done != exp_done) begin
            failures++;
            $display("FAIL count8_done_cycle got=%0d exp=%0d (-1 = timeout)", seen_done, exp_done);
        end
        checks++;
        if (refs != NREF8) begin
            failures++;
            $display("FAIL count8_refs got=%0d exp=%0d", refs, NREF8);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_timing();
        test_cl2();
        test_random();
        test_en_toggle();
        test_idle_hold();
        test_reset_mid();
        test_count8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
